// File: rtl/ip_sequencer.sv
// ip_sequencer: sole writer of the instruction pointer. It runs one fetch handshake
// per instruction, waits for one branch decision from decode, and then pulses the
// IP update with either STEP or the signed branch offset.
// Optional feature: define IP_SEQ_STATS_EN to add the instr_count and taken_count
// outputs. Both counters saturate.
module ip_sequencer #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned STEP      = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 run,
  input  logic                 restart,
  input  logic                 halt,
  input  logic [WORD_SIZE-1:0] ip,
  output logic                 fetch_req,
  output logic [WORD_SIZE-1:0] fetch_addr,
  input  logic                 fetch_ack,
  output logic                 branch_ready,
  input  logic                 branch_valid,
  input  logic                 branch_taken,
  input  logic [WORD_SIZE-1:0] branch_offset,
  output logic [WORD_SIZE-1:0] adj,
  output logic                 update_enable,
  output logic                 reset_enable,
  output logic [2:0]           state
`ifdef IP_SEQ_STATS_EN
  ,
  output logic [15:0]          instr_count,
  output logic [15:0]          taken_count
`endif
);

  typedef enum logic [2:0] {
    StClear  = 3'd0,
    StIdle   = 3'd1,
    StFetch  = 3'd2,
    StDecode = 3'd3,
    StUpdate = 3'd4,
    StHalted = 3'd5
  } state_e;

  state_e               state_q;
  logic [WORD_SIZE-1:0] adj_q;
  logic                 update_enable_q;
  logic                 reset_enable_q;

  // Sequencer FSM. Reset and restart both park in StClear so that the IP clears on
  // the edge that ends the StClear cycle.
  always_ff @(posedge clk) begin
    if (!reset_n || restart) begin
      state_q         <= StClear;
      adj_q           <= '0;
      update_enable_q <= 1'b0;
      reset_enable_q  <= 1'b1;
    end else begin
      reset_enable_q <= 1'b0;
      case (state_q)
        StClear: state_q <= StIdle;
        StIdle: begin
          if (run && !halt) state_q <= StFetch;
        end
        // A started fetch always completes. run is not sampled here.
        StFetch: begin
          if (fetch_ack) state_q <= StDecode;
        end
        StDecode: begin
          if (branch_valid) begin
            adj_q           <= branch_taken ? branch_offset : WORD_SIZE'(STEP);
            update_enable_q <= 1'b1;
            state_q         <= StUpdate;
          end
        end
        StUpdate: begin
          update_enable_q <= 1'b0;
          adj_q           <= '0;
          if (halt)      state_q <= StHalted;
          else if (!run) state_q <= StIdle;
          else           state_q <= StFetch;
        end
        StHalted: begin
          if (!halt) state_q <= StIdle;
        end
        default: begin
          state_q         <= StClear;
          update_enable_q <= 1'b0;
          reset_enable_q  <= 1'b1;
        end
      endcase
    end
  end

`ifdef IP_SEQ_STATS_EN
  logic [15:0] instr_count_q;
  logic [15:0] taken_count_q;
  logic        taken_q;

  // Statistics: the decision is latched in decode, then counted in the update cycle.
  always_ff @(posedge clk) begin
    if (!reset_n || restart) begin
      instr_count_q <= '0;
      taken_count_q <= '0;
      taken_q       <= 1'b0;
    end else begin
      if (state_q == StDecode && branch_valid) taken_q <= branch_taken;
      if (state_q == StUpdate) begin
        if (instr_count_q != 16'hFFFF) instr_count_q <= instr_count_q + 16'd1;
        if (taken_q && taken_count_q != 16'hFFFF) taken_count_q <= taken_count_q + 16'd1;
      end
    end
  end

  assign instr_count = instr_count_q;
  assign taken_count = taken_count_q;
`endif

  // The fetch and decode handshakes are Moore outputs. The IP controls are registered.
  assign fetch_req     = (state_q == StFetch);
  assign fetch_addr    = fetch_req ? ip : '0;
  assign branch_ready  = (state_q == StDecode);
  assign adj           = adj_q;
  assign update_enable = update_enable_q;
  assign reset_enable  = reset_enable_q;
  assign state         = state_q;

endmodule

// File: tb/tb_ip_sequencer.sv
// Directed bench for ip_sequencer. A local model of the instruction pointer register
// closes the loop. Each step compares the outputs with hand-computed values.
module tb_ip_sequencer;

  logic        clk = 1'b0;
  logic        reset_n, run, restart, halt;
  logic [15:0] ip;
  logic        fetch_req, fetch_ack, branch_ready, branch_valid, branch_taken;
  logic [15:0] fetch_addr, branch_offset, adj;
  logic        update_enable, reset_enable;
  logic [2:0]  state;
`ifdef IP_SEQ_STATS_EN
  logic [15:0] instr_count, taken_count;
`endif

  int checks = 0;
  int errors = 0;

  ip_sequencer #(.WORD_SIZE(16), .STEP(1)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .run           (run),
    .restart       (restart),
    .halt          (halt),
    .ip            (ip),
    .fetch_req     (fetch_req),
    .fetch_addr    (fetch_addr),
    .fetch_ack     (fetch_ack),
    .branch_ready  (branch_ready),
    .branch_valid  (branch_valid),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .adj           (adj),
    .update_enable (update_enable),
    .reset_enable  (reset_enable),
    .state         (state)
`ifdef IP_SEQ_STATS_EN
    ,
    .instr_count   (instr_count),
    .taken_count   (taken_count)
`endif
  );

  always #5 clk = ~clk;

  // Instruction pointer register that the sequencer drives.
  always @(posedge clk) begin
    if (reset_enable)       ip <= 16'h0000;
    else if (update_enable) ip <= ip + adj;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // On entry the DUT is in FETCH. On exit it is in UPDATE with the decision applied.
  task automatic run_instr(input logic tk, input logic [15:0] off,
                           input logic [15:0] exp_ip, input logic [15:0] exp_adj);
    chk("fetch_state", state, 32'd2);
    chk("fetch_req", fetch_req, 32'd1);
    chk("fetch_addr", fetch_addr, exp_ip);
    fetch_ack = 1'b1;
    tick();
    fetch_ack = 1'b0;
    chk("decode_state", state, 32'd3);
    chk("decode_ready", branch_ready, 32'd1);
    chk("decode_noreq", fetch_req, 32'd0);
    branch_valid  = 1'b1;
    branch_taken  = tk;
    branch_offset = off;
    tick();
    branch_valid = 1'b0;
    chk("update_state", state, 32'd4);
    chk("update_en", update_enable, 32'd1);
    chk("update_noclr", reset_enable, 32'd0);
    chk("update_adj", adj, exp_adj);
  endtask

  initial begin
    reset_n = 1'b0; run = 1'b0; restart = 1'b0; halt = 1'b0;
    fetch_ack = 1'b0; branch_valid = 1'b0; branch_taken = 1'b0; branch_offset = 16'h0;

    // Reset and the CLEAR cycle.
    tick();
    tick();
    chk("rst_state", state, 32'd0);
    chk("rst_clr", reset_enable, 32'd1);
    chk("rst_upd", update_enable, 32'd0);
    chk("rst_req", fetch_req, 32'd0);
    chk("rst_ready", branch_ready, 32'd0);
    chk("rst_adj", adj, 32'd0);
    reset_n = 1'b1;
    #1;
    chk("clear_clr", reset_enable, 32'd1);
    tick();
    chk("idle_state", state, 32'd1);
    chk("idle_clr", reset_enable, 32'd0);
    chk("idle_ip", ip, 32'd0);
    tick();
    chk("idle_stay", state, 32'd1);

    // Sequential advance: 0,1,2,3, with 3 cycles per instruction.
    run = 1'b1;
    tick();
    run_instr(1'b0, 16'h0, 16'h0000, 16'h0001); tick();
    run_instr(1'b0, 16'h0, 16'h0001, 16'h0001); tick();
    run_instr(1'b0, 16'h0, 16'h0002, 16'h0001); tick();
    chk("seq_ip3", ip, 32'd3);
    run_instr(1'b0, 16'h0, 16'h0003, 16'h0001); tick();

    // Backward branch to 0, wrap past 0xFFFF, then a self-loop with offset 0.
    run_instr(1'b1, 16'hFFFC, 16'h0004, 16'hFFFC); tick();
    chk("back_ip", ip, 32'd0);
    run_instr(1'b1, 16'hFFFF, 16'h0000, 16'hFFFF); tick();
    run_instr(1'b0, 16'h1234, 16'hFFFF, 16'h0001); tick();
    chk("wrap_ip", ip, 32'd0);
    run_instr(1'b1, 16'h0000, 16'h0000, 16'h0000); tick();
    chk("self_ip", ip, 32'd0);
    chk("self_state", state, 32'd2);

    // Halt raised during decode: the update still completes, then the DUT parks.
    fetch_ack = 1'b1;
    tick();
    fetch_ack = 1'b0;
    halt = 1'b1; branch_valid = 1'b1; branch_taken = 1'b0;
    tick();
    branch_valid = 1'b0;
    chk("halt_upd_state", state, 32'd4);
    chk("halt_upd_en", update_enable, 32'd1);
    tick();
    chk("halted_state", state, 32'd5);
    chk("halted_req", fetch_req, 32'd0);
    chk("halted_upd", update_enable, 32'd0);
    chk("halted_ip", ip, 32'd1);
    tick();
    chk("halted_stay", state, 32'd5);
    chk("halted_req2", fetch_req, 32'd0);
    halt = 1'b0;
    tick();
    chk("unhalt_idle", state, 32'd1);
    tick();
    chk("unhalt_fetch", state, 32'd2);
    chk("unhalt_addr", fetch_addr, 32'd1);

    // A stray decision in FETCH is ignored, then restart abandons the fetch.
    branch_valid = 1'b1; branch_taken = 1'b1; branch_offset = 16'h0007;
    tick();
    branch_valid = 1'b0;
    chk("stray_state", state, 32'd2);
    chk("stray_upd", update_enable, 32'd0);
    chk("stray_ip", ip, 32'd1);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("rs_state", state, 32'd0);
    chk("rs_clr", reset_enable, 32'd1);
    chk("rs_upd", update_enable, 32'd0);
    chk("rs_req", fetch_req, 32'd0);
`ifdef IP_SEQ_STATS_EN
    chk("rs_icount", instr_count, 32'd0);
    chk("rs_tcount", taken_count, 32'd0);
`endif
    tick();
    chk("rs_idle", state, 32'd1);
    chk("rs_ip", ip, 32'd0);
    tick();
    chk("rs_fetch", state, 32'd2);
    chk("rs_addr", fetch_addr, 32'd0);

    // Five instructions, two taken, ending with run dropped.
    run_instr(1'b0, 16'h0000, 16'h0000, 16'h0001); tick();
    run_instr(1'b1, 16'h0003, 16'h0001, 16'h0003); tick();
    run_instr(1'b0, 16'h0000, 16'h0004, 16'h0001); tick();
    run_instr(1'b1, 16'hFFFB, 16'h0005, 16'hFFFB); tick();
    run_instr(1'b0, 16'h0000, 16'h0000, 16'h0001);
    run = 1'b0;
    tick();
    chk("stop_idle", state, 32'd1);
    chk("stop_ip", ip, 32'd1);
`ifdef IP_SEQ_STATS_EN
    chk("icount5", instr_count, 32'd5);
    chk("tcount2", taken_count, 32'd2);
`endif
    tick();
    chk("stop_stay", state, 32'd1);
    chk("stop_req", fetch_req, 32'd0);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("rs2_state", state, 32'd0);
`ifdef IP_SEQ_STATS_EN
    chk("rs2_icount", instr_count, 32'd0);
    chk("rs2_tcount", taken_count, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
